// File: rtl/pll_dyn_pkg.sv
// pll_dyn_pkg: supervisor states, rPLL select encoding and default divider table
package pll_dyn_pkg;
    typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, FILTER, READY, FAULT} state_t;
    localparam logic [23:0] DEF_IDIV_TAB = {4{6'd0}};
    localparam logic [23:0] DEF_FBDIV_TAB = {4{6'd23}};
    localparam logic [23:0] DEF_ODSEL_TAB = {4{6'd62}};
    function automatic logic [5:0] sel_enc(input logic [5:0] v);
        return 6'd63 - v;
    endfunction
endpackage

// File: rtl/pll_dyn_ctrl_lock_sync.sv
// lock_sync: multi-flop synchroniser for the asynchronous PLL LOCK signal
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] s;
    always_ff @(posedge clk) begin
        if (!rst_n) s <= '0;
        else s <= {s[STAGES-2:0], d};
    end
    assign q = s[STAGES-1];
endmodule

// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: rPLL reset/lock supervisor with run-time divider reconfiguration
module pll_dyn_ctrl import pll_dyn_pkg::*; #(
    parameter int N_MODES = 4,
    parameter int MODE_W = 2,
    parameter int DEFAULT_MODE = 0,
    parameter logic [6*N_MODES-1:0] IDIV_TAB = DEF_IDIV_TAB,
    parameter logic [6*N_MODES-1:0] FBDIV_TAB = DEF_FBDIV_TAB,
    parameter logic [6*N_MODES-1:0] ODSEL_TAB = DEF_ODSEL_TAB,
    parameter int RST_CYCLES = 16,
    parameter int LOCK_FILT = 256,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY = 3
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic              mode_req,
    output logic              mode_ack,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic              pll_reset_p,
    output logic [5:0]        pll_idsel,
    output logic [5:0]        pll_fbdsel,
    output logic [5:0]        pll_odsel,
    output logic [MODE_W-1:0] cur_mode,
    output logic              clk_ready,
    output logic              fault,
    output logic [1:0]        retry_cnt
);
    localparam int CW = $clog2((RST_CYCLES > LOCK_FILT ? RST_CYCLES : LOCK_FILT) + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [1:0] MAXR = 2'(MAX_RETRY);
    localparam logic [MODE_W:0] NM = (MODE_W + 1)'(N_MODES);
    localparam logic [MODE_W-1:0] DEF = MODE_W'(DEFAULT_MODE);
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic [17:0] sel;
    logic [17:0] enc [2**MODE_W];
    logic lock_s, acc, bad, go, ent, pend;
    // unused table slots alias valid entries; they are never applied
    for (genvar g = 0; g < 2**MODE_W; g++) begin : g_enc
        localparam int E = g % N_MODES;
        assign enc[g] = {sel_enc(IDIV_TAB[6*E +: 6]), sel_enc(FBDIV_TAB[6*E +: 6]), ODSEL_TAB[6*E +: 6]};
    end
    lock_sync #(.STAGES(2)) u_sync (.clk(clkin), .rst_n(rst_n), .d(pll_lock), .q(lock_s));
    always_comb begin
        acc = mode_req && !mode_ack && (state == READY || state == FAULT);
        bad = acc && {1'b0, mode_sel} >= NM;
        go = acc && !bad;
        nxt = state;
        case (state)
            RST_PLL:   nxt = cnt == RST_LAST ? WAIT_LOCK : RST_PLL;
            WAIT_LOCK: nxt = lock_s ? FILTER : tcnt != TO_LAST ? WAIT_LOCK : retry_cnt < MAXR ? RST_PLL : FAULT;
            FILTER:    nxt = !lock_s ? WAIT_LOCK : cnt >= FILT_LAST ? READY : FILTER;
            READY:     nxt = lock_s ? READY : WAIT_LOCK;
            default:   nxt = FAULT;
        endcase
        nxt = go ? RST_PLL : bad ? state : nxt;
        ent = nxt != state && (nxt == READY || nxt == FAULT);
    end
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state <= RST_PLL;
            cnt <= '0;
            tcnt <= '0;
            retry_cnt <= '0;
            cur_mode <= DEF;
            sel <= enc[DEF];
            pll_reset <= 1'b1;
            clk_ready <= 1'b0;
            fault <= 1'b0;
            mode_ack <= 1'b0;
            pend <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= nxt == state ? cnt + 1'b1 : nxt == FILTER ? CW'(1) : '0;
            tcnt <= (state == WAIT_LOCK && nxt == WAIT_LOCK) ? tcnt + 1'b1 :
                    (state inside {WAIT_LOCK, FILTER} && nxt inside {WAIT_LOCK, FILTER}) ? tcnt : '0;
            retry_cnt <= (go || nxt == READY) ? '0 : retry_cnt + {1'b0, state == WAIT_LOCK && nxt == RST_PLL};
            cur_mode <= go ? mode_sel : cur_mode;
            sel <= go ? enc[mode_sel] : sel;
            pll_reset <= nxt == RST_PLL || nxt == FAULT;
            clk_ready <= nxt == READY;
            fault <= nxt == FAULT;
            mode_ack <= bad || (pend && ent);
            pend <= go || (pend && !ent);
        end
    end
    assign pll_reset_p = pll_reset;
    assign {pll_idsel, pll_fbdsel, pll_odsel} = sel;
endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// tb_pll_dyn_ctrl: directed bench checked every cycle against a countdown-style reference model
module tb_pll_dyn_ctrl;
    localparam int NM = 3, RSTC = 4, FILT = 8, TO = 32, MAXR = 2;
    localparam int IDIV [3] = '{0, 1, 2};
    localparam int FBDIV [3] = '{23, 36, 30};
    localparam int ODSEL [3] = '{62, 60, 61};

    logic clkin = 0, rst_n = 0, mode_req = 0, pll_lock = 0;
    logic [1:0] mode_sel = 0;
    logic mode_ack, pll_reset, pll_reset_p, clk_ready, fault;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [1:0] cur_mode, retry_cnt;
    int n_chk = 0, n_fail = 0;
    bit en = 0;

    pll_dyn_ctrl #(
        .N_MODES(NM), .MODE_W(2), .DEFAULT_MODE(0),
        .IDIV_TAB({6'd2, 6'd1, 6'd0}), .FBDIV_TAB({6'd30, 6'd36, 6'd23}), .ODSEL_TAB({6'd61, 6'd60, 6'd62}),
        .RST_CYCLES(RSTC), .LOCK_FILT(FILT), .LOCK_TIMEOUT(TO), .MAX_RETRY(MAXR)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .mode_sel(mode_sel), .mode_req(mode_req), .mode_ack(mode_ack),
        .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_reset_p(pll_reset_p), .pll_idsel(pll_idsel),
        .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel), .cur_mode(cur_mode), .clk_ready(clk_ready),
        .fault(fault), .retry_cnt(retry_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    // Reference model: reset pulse as a countdown, lock qualification as a run length,
    // lock seen through a two-sample delay line.
    int m_mode, m_left, m_timer, m_run, m_retries;
    bit m_ready, m_fault, m_ack, m_pend, h1, h2, ls, acc;
    always @(posedge clkin) begin
        if (!rst_n) begin
            m_mode = 0; m_left = RSTC; m_timer = 0; m_run = 0; m_retries = 0;
            m_ready = 0; m_fault = 0; m_ack = 0; m_pend = 0; h1 = 0; h2 = 0;
        end else begin
            ls = h2; h2 = h1; h1 = pll_lock;
            acc = mode_req && !m_ack && (m_ready || m_fault);
            m_ack = 0;
            if (acc && int'(mode_sel) >= NM) m_ack = 1;
            else if (acc) begin
                m_mode = int'(mode_sel); m_fault = 0; m_ready = 0; m_retries = 0;
                m_left = RSTC; m_pend = 1;
            end else if (m_fault) begin
                m_fault = 1;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin m_timer = 0; m_run = 0; end
            end else if (m_ready) begin
                if (!ls) begin m_ready = 0; m_timer = 0; m_run = 0; end
            end else if (ls) begin
                m_run++;
                if (m_run == FILT) begin
                    m_ready = 1; m_retries = 0;
                    if (m_pend) begin m_ack = 1; m_pend = 0; end
                end
            end else if (m_run > 0) m_run = 0;
            else if (m_timer == TO - 1) begin
                if (m_retries < MAXR) begin m_retries++; m_left = RSTC; end
                else begin
                    m_fault = 1;
                    if (m_pend) begin m_ack = 1; m_pend = 0; end
                end
            end else m_timer++;
        end
    end

    logic [17:0] prev_sel;
    always @(negedge clkin) if (en) begin
        chk("clk_ready", clk_ready, m_ready);
        chk("fault", fault, m_fault);
        chk("pll_reset", pll_reset, m_left > 0 || m_fault);
        chk("pll_reset_p", pll_reset_p, m_left > 0 || m_fault);
        chk("mode_ack", mode_ack, m_ack);
        chk("retry_cnt", retry_cnt, m_retries);
        chk("cur_mode", cur_mode, m_mode);
        chk("idsel", pll_idsel, 63 - IDIV[m_mode]);
        chk("fbdsel", pll_fbdsel, 63 - FBDIV[m_mode]);
        chk("odsel", pll_odsel, ODSEL[m_mode]);
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== prev_sel) chk("sel_change_under_reset", pll_reset, 1);
        prev_sel = {pll_idsel, pll_fbdsel, pll_odsel};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int w, n, acks, pulses, mr;
    bit rs, prev;
    initial begin
        cyc(3);
        en = 1;
        chk("reset_pll_reset", pll_reset, 1);
        chk("reset_clk_ready", clk_ready, 0);
        // bring-up
        rst_n = 1;
        w = 0;
        while (pll_reset && w < 20) begin w++; cyc(1); end
        chk("rst_pulse_len", w, 4);
        cyc(6);
        pll_lock = 1;
        n = 0;
        while (!clk_ready && n < 50) begin cyc(1); n++; end
        chk("ready_latency", n, 10);
        chk("idsel_default", pll_idsel, 63);
        chk("fbdsel_default", pll_fbdsel, 40);
        chk("odsel_default", pll_odsel, 62);
        // lock loss in READY, then glitchy relock
        cyc(2);
        pll_lock = 0;
        n = 0;
        while (clk_ready && n < 20) begin cyc(1); n++; end
        chk("loss_latency", n, 3);
        chk("no_reset_on_loss", pll_reset, 0);
        rs = 0;
        cyc(2);
        pll_lock = 1;
        repeat (5) begin cyc(1); rs |= pll_reset; end
        pll_lock = 0;
        cyc(1);
        pll_lock = 1;
        n = 0;
        while (!clk_ready && n < 50) begin cyc(1); n++; rs |= pll_reset; end
        chk("glitch_latency", n, 10);
        chk("glitch_no_reset", rs, 0);
        // mode switch to entry 1
        cyc(2);
        mode_sel = 1;
        mode_req = 1;
        cyc(1);
        chk("switch_ready_drop", clk_ready, 0);
        chk("switch_reset", pll_reset, 1);
        chk("switch_fbdsel", pll_fbdsel, 27);
        chk("switch_mode", cur_mode, 1);
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            if (mode_ack) begin acks++; chk("ack_with_ready", clk_ready, 1); mode_req = 0; end
            cyc(1);
        end
        chk("switch_ack_count", acks, 1);
        chk("switch_relocked", clk_ready, 1);
        // invalid mode
        mode_sel = 3;
        mode_req = 1;
        cyc(1);
        chk("reject_ack", mode_ack, 1);
        chk("reject_ready", clk_ready, 1);
        chk("reject_mode", cur_mode, 1);
        chk("reject_fbdsel", pll_fbdsel, 27);
        mode_req = 0;
        cyc(1);
        chk("reject_ack_single", mode_ack, 0);
        // timeout and fault
        rst_n = 0;
        pll_lock = 0;
        cyc(2);
        rst_n = 1;
        pulses = 0; mr = 0; prev = 1; n = 0;
        while (!fault && n < 400) begin
            cyc(1); n++;
            if (prev && !pll_reset) pulses++;
            prev = pll_reset;
            if (int'(retry_cnt) > mr) mr = int'(retry_cnt);
        end
        chk("fault_latency", n, 108);
        chk("fault_pulses", pulses, 3);
        chk("fault_max_retry", mr, 2);
        cyc(5);
        chk("fault_sticky", fault, 1);
        chk("fault_reset_held", pll_reset, 1);
        // leave FAULT through a mode request
        mode_sel = 2;
        mode_req = 1;
        pll_lock = 1;
        cyc(1);
        chk("fault_exit", fault, 0);
        chk("fault_exit_mode", cur_mode, 2);
        chk("fault_exit_idsel", pll_idsel, 61);
        n = 0;
        while (!mode_ack && n < 40) begin cyc(1); n++; end
        chk("fault_relock_latency", n, 12);
        chk("fault_relock_ready", clk_ready, 1);
        mode_req = 0;
        // reset in the middle of FILTER
        cyc(1);
        pll_lock = 0;
        cyc(4);
        pll_lock = 1;
        cyc(5);
        chk("mid_filter_not_ready", clk_ready, 0);
        rst_n = 0;
        cyc(1);
        chk("rst_mid_pll_reset", pll_reset, 1);
        chk("rst_mid_ready", clk_ready, 0);
        chk("rst_mid_mode", cur_mode, 0);
        chk("rst_mid_idsel", pll_idsel, 63);
        chk("rst_mid_fbdsel", pll_fbdsel, 40);
        chk("rst_mid_odsel", pll_odsel, 62);
        chk("rst_mid_fault", fault, 0);
        chk("rst_mid_retry", retry_cnt, 0);
        rst_n = 1;
        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
